// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller:
// state encoding, request length codes and the IO region select.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      MC_IDLE   = 2'd0,
      MC_IFETCH = 2'd1,
      MC_LOAD   = 2'd2,
      MC_STORE  = 2'd3
   } mc_state_t;

   localparam logic [1:0] LEN_B = 2'd0;
   localparam logic [1:0] LEN_H = 2'd1;
   localparam logic [1:0] LEN_W = 2'd2;

   localparam logic [1:0] IO_SEL = 2'b11;

   // Index of the final byte beat for a length code; code 3 behaves as a word.
   function automatic logic [1:0] last_beat(input logic [1:0] len);
      case (len)
         LEN_B:   return 2'd0;
         LEN_H:   return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the memory controller, the 8-bit RAM/IO port and the
// two requesters (ICache miss path and load/store buffer).
interface mem_ctrl_if;

   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   logic        ic_req;
   logic [31:0] ic_addr;
   logic [31:0] ic_data;
   logic        ic_ready;

   logic        lsb_req;
   logic        lsb_wr;
   logic [1:0]  lsb_len;
   logic [31:0] lsb_addr;
   logic [31:0] lsb_wdata;
   logic [31:0] lsb_rdata;
   logic        lsb_ready;

   modport slave (
      input  mem_din, io_buffer_full,
      input  ic_req, ic_addr,
      input  lsb_req, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
      output mem_dout, mem_a, mem_wr,
      output ic_data, ic_ready,
      output lsb_rdata, lsb_ready
   );

   modport master (
      output mem_din, io_buffer_full,
      output ic_req, ic_addr,
      output lsb_req, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
      input  mem_dout, mem_a, mem_wr,
      input  ic_data, ic_ready,
      input  lsb_rdata, lsb_ready
   );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates ICache fetches and LSB accesses
// onto the 8-bit RAM/IO bus, one byte beat per clock, little-endian.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter logic [1:0] IO_MASK = IO_SEL
) (
   input  logic     clk_in,
   input  logic     rst_in,
   input  logic     rdy_in,
   input  logic     clear,
   mem_ctrl_if.slave bus
);

   mc_state_t       state, state_nxt;
   logic [1:0]      cnt, cnt_nxt;
   logic [1:0]      last, last_nxt;
   logic [31:0]     addr_q, addr_nxt;
   logic [31:0]     wdata_q, wdata_nxt;
   logic [3:0][7:0] rbuf, rbuf_nxt;

   logic [31:0]     mem_a_q, mem_a_nxt;
   logic [7:0]      mem_dout_q, mem_dout_nxt;
   logic            mem_wr_q, mem_wr_nxt;
   logic [31:0]     ic_data_q, ic_data_nxt;
   logic            ic_ready_q, ic_ready_nxt;
   logic [31:0]     lsb_rdata_q, lsb_rdata_nxt;
   logic            lsb_ready_q, lsb_ready_nxt;

   logic            accept_ok;
   logic            io_stall_new;
   logic            io_stall_cur;
   logic [1:0]      beat;
   logic [3:0][7:0] rd_word;

   // A requester drops its level request on the edge after its ready pulse,
   // so IDLE must not accept while any ready pulse is still up.
   assign accept_ok    = !clear && !ic_ready_q && !lsb_ready_q;
   assign io_stall_new = (bus.lsb_addr[17:16] == IO_MASK) && bus.io_buffer_full;
   assign io_stall_cur = (addr_q[17:16] == IO_MASK) && bus.io_buffer_full;
   assign beat         = mem_wr_q ? cnt + 2'd1 : cnt;

   always_comb begin
      rd_word      = rbuf;
      rd_word[cnt] = bus.mem_din;
      for (int i = 0; i < 4; i++) begin
         if (i > int'(last)) rd_word[i] = 8'h00;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)     state <= MC_IDLE;
      else if (rdy_in) state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MC_IDLE: begin
            if (accept_ok) begin
               if (bus.lsb_req)     state_nxt = bus.lsb_wr ? MC_STORE : MC_LOAD;
               else if (bus.ic_req) state_nxt = MC_IFETCH;
            end
         end
         MC_IFETCH, MC_LOAD: begin
            if (clear || cnt == last) state_nxt = MC_IDLE;
         end
         MC_STORE: begin
            if (mem_wr_q && cnt == last) state_nxt = MC_IDLE;
         end
         default: state_nxt = MC_IDLE;
      endcase
   end

   // In STORE, cnt names the beat on the bus (mem_wr_q=1) or the beat still
   // waiting for the IO buffer (mem_wr_q=0); stores ignore clear.
   always_comb begin
      cnt_nxt       = cnt;
      last_nxt      = last;
      addr_nxt      = addr_q;
      wdata_nxt     = wdata_q;
      rbuf_nxt      = rbuf;
      mem_a_nxt     = mem_a_q;
      mem_dout_nxt  = mem_dout_q;
      mem_wr_nxt    = 1'b0;
      ic_data_nxt   = ic_data_q;
      ic_ready_nxt  = 1'b0;
      lsb_rdata_nxt = lsb_rdata_q;
      lsb_ready_nxt = 1'b0;
      case (state)
         MC_IDLE: begin
            if (accept_ok && (bus.lsb_req || bus.ic_req)) begin
               cnt_nxt = 2'd0;
               if (bus.lsb_req) begin
                  addr_nxt  = bus.lsb_addr;
                  last_nxt  = last_beat(bus.lsb_len);
                  wdata_nxt = bus.lsb_wdata;
                  mem_a_nxt = bus.lsb_addr;
                  if (bus.lsb_wr) begin
                     mem_dout_nxt = bus.lsb_wdata[7:0];
                     mem_wr_nxt   = !io_stall_new;
                  end
               end else begin
                  addr_nxt  = bus.ic_addr;
                  last_nxt  = last_beat(LEN_W);
                  mem_a_nxt = bus.ic_addr;
               end
            end
         end
         MC_IFETCH, MC_LOAD: begin
            if (clear) begin
               mem_a_nxt = 32'd0;
               cnt_nxt   = 2'd0;
            end else begin
               rbuf_nxt[cnt] = bus.mem_din;
               if (cnt == last) begin
                  mem_a_nxt = 32'd0;
                  cnt_nxt   = 2'd0;
                  if (state == MC_IFETCH) begin
                     ic_data_nxt  = rd_word;
                     ic_ready_nxt = 1'b1;
                  end else begin
                     lsb_rdata_nxt = rd_word;
                     lsb_ready_nxt = 1'b1;
                  end
               end else begin
                  mem_a_nxt = addr_q + 32'(cnt) + 32'd1;
                  cnt_nxt   = cnt + 2'd1;
               end
            end
         end
         MC_STORE: begin
            if (mem_wr_q && cnt == last) begin
               mem_a_nxt     = 32'd0;
               cnt_nxt       = 2'd0;
               lsb_ready_nxt = 1'b1;
            end else begin
               cnt_nxt      = beat;
               mem_a_nxt    = addr_q + 32'(beat);
               mem_dout_nxt = wdata_q[{beat, 3'b000} +: 8];
               mem_wr_nxt   = !io_stall_cur;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cnt         <= 2'd0;
         last        <= 2'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         rbuf        <= '0;
         mem_a_q     <= 32'd0;
         mem_dout_q  <= 8'd0;
         mem_wr_q    <= 1'b0;
         ic_data_q   <= 32'd0;
         ic_ready_q  <= 1'b0;
         lsb_rdata_q <= 32'd0;
         lsb_ready_q <= 1'b0;
      end else if (rdy_in) begin
         cnt         <= cnt_nxt;
         last        <= last_nxt;
         addr_q      <= addr_nxt;
         wdata_q     <= wdata_nxt;
         rbuf        <= rbuf_nxt;
         mem_a_q     <= mem_a_nxt;
         mem_dout_q  <= mem_dout_nxt;
         mem_wr_q    <= mem_wr_nxt;
         ic_data_q   <= ic_data_nxt;
         ic_ready_q  <= ic_ready_nxt;
         lsb_rdata_q <= lsb_rdata_nxt;
         lsb_ready_q <= lsb_ready_nxt;
      end
   end

   assign bus.mem_a     = mem_a_q;
   assign bus.mem_dout  = mem_dout_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.ic_data   = ic_data_q;
   assign bus.ic_ready  = ic_ready_q;
   assign bus.lsb_rdata = lsb_rdata_q;
   assign bus.lsb_ready = lsb_ready_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed scenarios plus random traffic,
// checked against a byte-array memory model with queued expectations.
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   logic rdy;
   logic clear;

   mem_ctrl_if bus();

   mem_ctrl dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .rdy_in (rdy),
      .clear  (clear),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  ram     [65536];
   logic [7:0]  ref_mem [65536];
   logic [31:0] exp_ic  [$];
   logic [31:0] exp_lsb [$];
   beat_t       exp_wr  [$];
   logic [31:0] last_load;
   logic        io_force;
   logic        io_rand_en;
   int          checks = 0;
   int          passes = 0;

   assign bus.mem_din = ram[bus.mem_a[15:0]];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic int nbytes(input logic [1:0] len);
      return (len == LEN_B) ? 1 : ((len == LEN_H) ? 2 : 4);
   endfunction

   function automatic logic [31:0] modelRead(input logic [31:0] a, input logic [1:0] len);
      logic [31:0] v;
      logic [31:0] p;
      v = 32'd0;
      for (int i = 0; i < nbytes(len); i++) begin
         p = a + 32'(i);
         v[8*i +: 8] = ref_mem[p[15:0]];
      end
      return v;
   endfunction

   task automatic modelStore(input logic [31:0] a, input logic [1:0] len, input logic [31:0] wd);
      logic [31:0] p;
      for (int i = 0; i < nbytes(len); i++) begin
         p = a + 32'(i);
         exp_wr.push_back('{p, wd[8*i +: 8]});
         ref_mem[p[15:0]] = wd[8*i +: 8];
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      ram[a]     = d;
      ref_mem[a] = d;
   endtask

   task automatic stepEdge;
      @(posedge clk);
      #1;
   endtask

   task automatic waitLsb;
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.lsb_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) checkOutput("lsb_ready_timeout", 32'd0, 32'd1);
      bus.lsb_req = 1'b0;
   endtask

   task automatic waitIc;
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (bus.ic_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) checkOutput("ic_ready_timeout", 32'd0, 32'd1);
      bus.ic_req = 1'b0;
   endtask

   task automatic lsbOp(input logic wr, input logic [1:0] len, input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      if (wr) modelStore(a, len, wd);
      else    last_load = modelRead(a, len);
      exp_lsb.push_back(last_load);
      bus.lsb_wr    = wr;
      bus.lsb_len   = len;
      bus.lsb_addr  = a;
      bus.lsb_wdata = wd;
      bus.lsb_req   = 1'b1;
      waitLsb();
   endtask

   task automatic icFetch(input logic [31:0] a);
      @(negedge clk);
      exp_ic.push_back(modelRead(a, LEN_W));
      bus.ic_addr = a;
      bus.ic_req  = 1'b1;
      waitIc();
   endtask

   task automatic applyStimulus(input int n);
      io_rand_en = 1'b1;
      fork
         begin
            for (int k = 0; k < n; k++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               icFetch(32'h400 + 32'($urandom_range(0, 32'hBF0)));
            end
         end
         begin
            for (int k = 0; k < 2 * n; k++) begin
               logic        wr;
               logic [1:0]  len;
               logic [31:0] a;
               repeat ($urandom_range(0, 3)) @(negedge clk);
               wr  = 1'($urandom_range(0, 1));
               len = 2'($urandom_range(0, 3));
               if (wr) a = ($urandom_range(0, 1) != 0 ? 32'h31000 : 32'h1000) + 32'($urandom_range(0, 32'hFF0));
               else    a = 32'h400 + 32'($urandom_range(0, 32'h1BF0));
               lsbOp(wr, len, a, $urandom());
            end
         end
      join
      io_rand_en = 1'b0;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_mem_a"},     bus.mem_a,            32'd0);
      checkOutput({tag, "_mem_dout"},  32'(bus.mem_dout),    32'd0);
      checkOutput({tag, "_mem_wr"},    32'(bus.mem_wr),      32'd0);
      checkOutput({tag, "_ic_data"},   bus.ic_data,          32'd0);
      checkOutput({tag, "_ic_ready"},  32'(bus.ic_ready),    32'd0);
      checkOutput({tag, "_lsb_rdata"}, bus.lsb_rdata,        32'd0);
      checkOutput({tag, "_lsb_ready"}, 32'(bus.lsb_ready),   32'd0);
   endtask

   initial begin
      logic [31:0] fetch_a [5];
      fetch_a = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h0};
      rst_n = 1'b0; rdy = 1'b1; clear = 1'b0;
      io_force = 1'b0; io_rand_en = 1'b0; last_load = 32'd0;
      bus.ic_req = 1'b0; bus.ic_addr = 32'd0;
      bus.lsb_req = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_len = 2'd0;
      bus.lsb_addr = 32'd0; bus.lsb_wdata = 32'd0; bus.io_buffer_full = 1'b0;
      for (int i = 0; i < 65536; i++) begin
         ram[i]     = 8'($urandom());
         ref_mem[i] = ram[i];
      end
      poke(16'h0100, 8'h13); poke(16'h0101, 8'h05); poke(16'h0102, 8'h00); poke(16'h0103, 8'h00);
      poke(16'h2002, 8'h34); poke(16'h2003, 8'h12); poke(16'hFFFF, 8'h5A);

      // Monitor: one pop per registered output event; frozen cycles are skipped.
      fork
         forever begin
            @(posedge clk);
            #1;
            if (rst_n && rdy) begin
               if (bus.ic_ready) begin
                  if (exp_ic.size() == 0) checkOutput("ic_ready_unexpected", 32'd1, 32'd0);
                  else checkOutput("ic_data", bus.ic_data, exp_ic.pop_front());
               end
               if (bus.lsb_ready) begin
                  if (exp_lsb.size() == 0) checkOutput("lsb_ready_unexpected", 32'd1, 32'd0);
                  else checkOutput("lsb_rdata", bus.lsb_rdata, exp_lsb.pop_front());
               end
               if (bus.mem_wr) begin
                  beat_t b;
                  ram[bus.mem_a[15:0]] = bus.mem_dout;
                  if (exp_wr.size() == 0) checkOutput("write_unexpected", bus.mem_a, 32'hFFFFFFFF);
                  else begin
                     b = exp_wr.pop_front();
                     checkOutput("write_addr", bus.mem_a, b.a);
                     checkOutput("write_data", 32'(bus.mem_dout), 32'(b.d));
                  end
               end
            end
         end
         forever begin
            @(negedge clk);
            #1;
            bus.io_buffer_full = io_rand_en ? ($urandom_range(0, 3) == 0) : io_force;
         end
      join_none

      #12;
      checkResetOutputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] word fetch at 0x100");
      @(negedge clk);
      exp_ic.push_back(32'h00000513);
      bus.ic_addr = 32'h100;
      bus.ic_req  = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         stepEdge();
         checkOutput($sformatf("fetch_mem_a_e%0d", e), bus.mem_a, fetch_a[e-1]);
         checkOutput($sformatf("fetch_ready_e%0d", e), 32'(bus.ic_ready), (e == 5) ? 32'd1 : 32'd0);
      end
      stepEdge();
      checkOutput("no_reaccept_mem_a", bus.mem_a, 32'd0);
      checkOutput("ready_one_cycle", 32'(bus.ic_ready), 32'd0);
      @(negedge clk);
      bus.ic_req = 1'b0;

      $display("[TB] simultaneous requests, LSB half load first");
      @(negedge clk);
      exp_ic.push_back(modelRead(32'h104, LEN_W));
      last_load = modelRead(32'h2002, LEN_H);
      exp_lsb.push_back(last_load);
      bus.ic_addr = 32'h104; bus.ic_req = 1'b1;
      bus.lsb_wr = 1'b0; bus.lsb_len = LEN_H; bus.lsb_addr = 32'h2002; bus.lsb_req = 1'b1;
      stepEdge(); checkOutput("prio_mem_a_e1", bus.mem_a, 32'h2002);
      stepEdge(); checkOutput("prio_mem_a_e2", bus.mem_a, 32'h2003);
      stepEdge();
      checkOutput("half_ready_e3", 32'(bus.lsb_ready), 32'd1);
      checkOutput("half_rdata", bus.lsb_rdata, 32'h00001234);
      @(negedge clk);
      bus.lsb_req = 1'b0;
      stepEdge(); checkOutput("ic_blocked_mem_a", bus.mem_a, 32'd0);
      stepEdge(); checkOutput("ic_accept_mem_a", bus.mem_a, 32'h104);
      waitIc();

      $display("[TB] word store and read-back");
      lsbOp(1'b1, LEN_W, 32'h1000, 32'hDEADBEEF);
      stepEdge();
      checkOutput("store_mem_wr_after", 32'(bus.mem_wr), 32'd0);
      lsbOp(1'b0, LEN_W, 32'h1000, 32'd0);
      checkOutput("store_readback", bus.lsb_rdata, 32'hDEADBEEF);

      $display("[TB] IO byte store with buffer full");
      @(negedge clk);
      io_force = 1'b1;
      modelStore(32'h30000, LEN_B, 32'h000000A5);
      exp_lsb.push_back(last_load);
      bus.lsb_wr = 1'b1; bus.lsb_len = LEN_B; bus.lsb_addr = 32'h30000;
      bus.lsb_wdata = 32'h000000A5; bus.lsb_req = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         stepEdge();
         checkOutput($sformatf("io_stall_wr_e%0d", e), 32'(bus.mem_wr), 32'd0);
      end
      @(negedge clk);
      io_force = 1'b0;
      stepEdge(); checkOutput("io_beat_wr", 32'(bus.mem_wr), 32'd1);
      stepEdge();
      checkOutput("io_ready", 32'(bus.lsb_ready), 32'd1);
      checkOutput("io_wr_dropped", 32'(bus.mem_wr), 32'd0);
      @(negedge clk);
      bus.lsb_req = 1'b0;

      $display("[TB] clear during fetch and during store");
      @(negedge clk);
      bus.ic_addr = 32'h200; bus.ic_req = 1'b1;
      repeat (3) stepEdge();
      checkOutput("clear_pre_mem_a", bus.mem_a, 32'h202);
      @(negedge clk);
      clear = 1'b1; bus.ic_req = 1'b0;
      stepEdge();
      checkOutput("clear_mem_a", bus.mem_a, 32'd0);
      checkOutput("clear_no_ready", 32'(bus.ic_ready), 32'd0);
      @(negedge clk);
      clear = 1'b0;
      stepEdge();
      checkOutput("clear_still_no_ready", 32'(bus.ic_ready), 32'd0);
      fork
         lsbOp(1'b1, LEN_W, 32'h1100, 32'h12345678);
         begin
            repeat (3) @(negedge clk);
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
         end
      join
      lsbOp(1'b0, LEN_W, 32'h1100, 32'd0);

      $display("[TB] reset during load");
      @(negedge clk);
      bus.lsb_wr = 1'b0; bus.lsb_len = LEN_W; bus.lsb_addr = 32'h1000; bus.lsb_req = 1'b1;
      stepEdge();
      stepEdge();
      #2;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("midreset");
      @(negedge clk);
      bus.lsb_req = 1'b0;
      last_load   = 32'd0;
      rst_n       = 1'b1;

      $display("[TB] ready pause during fetch");
      @(negedge clk);
      exp_ic.push_back(32'h00000513);
      bus.ic_addr = 32'h100; bus.ic_req = 1'b1;
      stepEdge();
      stepEdge();
      @(negedge clk);
      rdy = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         stepEdge();
         checkOutput($sformatf("pause_mem_a_c%0d", e), bus.mem_a, 32'h101);
      end
      @(negedge clk);
      rdy = 1'b1;
      waitIc();

      $display("[TB] wrapping half load");
      lsbOp(1'b0, LEN_H, 32'hFFFFFFFF, 32'd0);
      checkOutput("wrap_half", bus.lsb_rdata, 32'h0000A55A);

      $display("[TB] random traffic");
      applyStimulus(25);

      repeat (10) @(negedge clk);
      checkOutput("ic_queue_drained",  32'(exp_ic.size()),  32'd0);
      checkOutput("lsb_queue_drained", 32'(exp_lsb.size()), 32'd0);
      checkOutput("wr_queue_drained",  32'(exp_wr.size()),  32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
